// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad front end (scanner and debouncer).
package keypad_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_t;

  // 1 ms per row at the 3 MHz system clock.
  localparam int ROW_DWELL_DEFAULT = 3000;

  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // One-hot-low drive pattern for a given row index.
  function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
    return ~(4'b0001 << row_idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the raw column pins; idles high to match the pull-ups.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_sync
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning keypad front end: rotates a low row, freezes on a hit and holds it for the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL = ROW_DWELL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  input  logic       scan_stop,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic [3:0] col,
  output logic       key_detected
);

  localparam int CNT_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_DWELL - 1);

  scan_state_t      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             key_detected_q, key_detected_d;

  logic [3:0]       col_sync;
  logic             hit_any;
  logic [1:0]       hit_idx;

  sync_2ff #(.W(4)) u_col_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (col_in),
    .d_sync (col_sync)
  );

  // Lowest-index low column wins when several are pressed on the same row.
  always_comb begin
    hit_any = ~&col_sync;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_sync[i]) hit_idx = 2'(i);
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    row_d          = row_q;
    key_code_d     = key_code_q;
    col_d          = col_q;
    col_idx_d      = col_idx_q;
    key_detected_d = key_detected_q;

    case (state_q)
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          if (hit_any) begin
            key_code_d     = key_map(idx_q, hit_idx);
            col_d          = ~(4'b0001 << hit_idx);
            col_idx_d      = hit_idx;
            key_detected_d = 1'b1;
            state_d        = HOLD;
          end else begin
            idx_d = idx_q + 2'd1;
            cnt_d = '0;
            row_d = row_drive(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        // Bounce only toggles the detect flag; code and column stay latched.
        key_detected_d = ~col_sync[col_idx_q];
        if (col_sync[col_idx_q] && !scan_stop) begin
          key_detected_d = 1'b0;
          key_code_d     = 4'h0;
          col_d          = 4'hF;
          idx_d          = idx_q + 2'd1;
          cnt_d          = '0;
          row_d          = row_drive(idx_q + 2'd1);
          state_d        = SCAN;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SCAN;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      row_q          <= 4'b1110;
      key_code_q     <= 4'h0;
      col_q          <= 4'hF;
      col_idx_q      <= 2'd0;
      key_detected_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      row_q          <= row_d;
      key_code_q     <= key_code_d;
      col_q          <= col_d;
      col_idx_q      <= col_idx_d;
      key_detected_q <= key_detected_d;
    end
  end

  assign row          = row_q;
  assign key_code     = key_code_q;
  assign col          = col_q;
  assign key_detected = key_detected_q;

endmodule
